// File: rtl/mask_row_loader.sv
// Buffers mask rows in a small FIFO, shifts each row serially into the sensor
// mask chain, then strobes a row latch carrying the row address.
module mask_row_loader #(
  parameter int max_image_sensor_w = 50,
  parameter int max_image_sensor_h = 50,
  parameter int fifo_depth         = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              clk_en,
  input  logic [10:0]                       image_sensor_w,
  input  logic [10:0]                       image_sensor_h,
  input  logic [0:max_image_sensor_w-1]     mg_mask,
  input  logic                              rp_valid,
  output logic                              sens_mask_data,
  output logic                              sens_mask_shift,
  output logic                              sens_row_load,
  output logic [10:0]                       sens_row_addr,
  output logic                              sens_frame_done,
  output logic [$clog2(fifo_depth):0]       fifo_level,
  output logic                              overflow
);

  // state | meaning
  // IDLE  | no row in flight, waiting for a FIFO entry
  // SHIFT | serial bits on the chain, counting down to bit 0
  // LOAD  | latch strobe with row address; may pop the next row
  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

  localparam int PW = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam int LW = $clog2(fifo_depth) + 1;
  localparam int IW = (max_image_sensor_w > 1) ? $clog2(max_image_sensor_w) : 1;

  logic [0:max_image_sensor_w-1] mem_q [fifo_depth];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] count_q, count_d;
  logic          ovf_q;

  state_t                        state_q, state_d;
  logic [0:max_image_sensor_w-1] row_q, row_d;
  logic [IW-1:0]                 idx_q, idx_d;
  logic [10:0]                   h_last_q, h_last_d;
  logic [10:0]                   row_cnt_q, row_cnt_d;
  logic                          data_q, data_d;
  logic                          shift_q, shift_d;
  logic                          load_q, load_d;
  logic [10:0]                   addr_q, addr_d;
  logic                          fd_q, fd_d;

  logic          empty, full, pop, push, drop;
  logic [10:0]   w_eff, h_eff;
  logic [IW-1:0] w_last;
  logic [0:max_image_sensor_w-1] head;

  always_comb begin
    w_eff = image_sensor_w;
    if (image_sensor_w == 11'd0)
      w_eff = 11'd1;
    else if (image_sensor_w > 11'(max_image_sensor_w))
      w_eff = 11'(max_image_sensor_w);
    h_eff = image_sensor_h;
    if (image_sensor_h == 11'd0)
      h_eff = 11'd1;
    else if (image_sensor_h > 11'(max_image_sensor_h))
      h_eff = 11'(max_image_sensor_h);
  end

  assign w_last = IW'(w_eff - 11'd1);
  assign head   = mem_q[rd_ptr_q];
  assign empty  = (count_q == '0);
  assign full   = (count_q == LW'(fifo_depth));
  assign pop    = clk_en && !empty && ((state_q == IDLE) || (state_q == LOAD));
  // A full FIFO still accepts a row when the same cycle frees a slot.
  assign push   = clk_en && rp_valid && (!full || pop);
  assign drop   = clk_en && rp_valid && full && !pop;

  always_comb begin
    count_d = count_q;
    if (push && !pop)
      count_d = count_q + LW'(1);
    else if (pop && !push)
      count_d = count_q - LW'(1);
  end

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    idx_d     = idx_q;
    h_last_d  = h_last_q;
    row_cnt_d = row_cnt_q;
    data_d    = data_q;
    shift_d   = shift_q;
    load_d    = load_q;
    addr_d    = addr_q;
    fd_d      = fd_q;
    case (state_q)
      SHIFT: begin
        if (idx_q == '0) begin
          shift_d   = 1'b0;
          data_d    = 1'b0;
          load_d    = 1'b1;
          addr_d    = row_cnt_q;
          fd_d      = (row_cnt_q == h_last_q);
          row_cnt_d = (row_cnt_q >= h_last_q) ? 11'd0 : row_cnt_q + 11'd1;
          state_d   = LOAD;
        end else begin
          idx_d  = idx_q - IW'(1);
          data_d = row_q[idx_q - IW'(1)];
        end
      end
      LOAD: begin
        load_d  = 1'b0;
        fd_d    = 1'b0;
        state_d = IDLE;
      end
      default: ;
    endcase
    // Pop from IDLE or straight out of LOAD starts the next row.
    if (pop) begin
      row_d    = head;
      idx_d    = w_last;
      data_d   = head[w_last];
      shift_d  = 1'b1;
      h_last_d = h_eff - 11'd1;
      state_d  = SHIFT;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= mg_mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      state_q   <= IDLE;
      row_q     <= '0;
      idx_q     <= '0;
      h_last_q  <= '0;
      row_cnt_q <= '0;
      data_q    <= 1'b0;
      shift_q   <= 1'b0;
      load_q    <= 1'b0;
      addr_q    <= '0;
      fd_q      <= 1'b0;
    end else if (clk_en) begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q   <= count_d;
      ovf_q     <= ovf_q | drop;
      state_q   <= state_d;
      row_q     <= row_d;
      idx_q     <= idx_d;
      h_last_q  <= h_last_d;
      row_cnt_q <= row_cnt_d;
      data_q    <= data_d;
      shift_q   <= shift_d;
      load_q    <= load_d;
      addr_q    <= addr_d;
      fd_q      <= fd_d;
    end
  end

  assign sens_mask_data  = data_q;
  assign sens_mask_shift = shift_q;
  assign sens_row_load   = load_q;
  assign sens_row_addr   = addr_q;
  assign sens_frame_done = fd_q;
  assign fifo_level      = count_q;
  assign overflow        = ovf_q;

endmodule
